oled_spi_link_rx: RTL and testbench
===================================

Name: oled_spi_link_rx

Overview:
- Slave-side receiver for the OLED SPI signals that the master board forwards raw over the inter-board PMOD link.
- Synchronises the link wires into clk and decodes mode-0 SPI frames into {d_cn, byte} records.
- Buffers records in a small FIFO with valid/ready output, so the slave can buffer, re-drive or inspect the OLED command/data stream rather than wire it straight through.
- Also passes resn/vccen/pmoden through synchronisers.

Parameters:
FIFO_DEPTH, 16, record FIFO entries; power of two, minimum 2
SYNC_STAGES, 2, synchroniser flops per link input; minimum 2

Ports:
clk  in  1  system clock (100 MHz); link sclk ≤ clk/8
reset  in  1  synchronous, active-high reset
link_cs  in  1  forwarded OLED chip select, active low
link_sdin  in  1  forwarded SPI data, MSB first
link_sclk  in  1  forwarded SPI clock, idle low
link_d_cn  in  1  forwarded data/command select
link_resn  in  1  forwarded OLED reset
link_vccen  in  1  forwarded VCC enable
link_pmoden  in  1  forwarded PMOD power enable
rx_data  out  8  head record byte
rx_dc  out  1  head record d_cn (1 = data, 0 = command)
rx_valid  out  1  FIFO non-empty
rx_ready  in  1  consumer accepts head record
rx_overflow  out  1  sticky: a completed byte was dropped because the FIFO was full
frame_abort  out  1  one-cycle pulse: cs deasserted mid-byte
byte_count  out  16  count of accepted bytes, wraps
resn_out  out  1  synchronised link_resn
vccen_out  out  1  synchronised link_vccen
pmoden_out  out  1  synchronised link_pmoden

Behaviour:
- Synchronisation and edge detection:
  - Every link_* input passes through a SYNC_STAGES flop chain.
  - Edge detection uses one extra register on synced sclk and synced cs.
- Reset (synchronous, active-high, takes priority at every point, including mid-frame):
  - FIFO empty; rx_valid 0; rx_data 0x00; rx_dc 0; rx_overflow 0; frame_abort 0; byte_count 0.
  - resn_out 0; vccen_out 0; pmoden_out 0.
  - Shift register and bit counter cleared; FSM returns to IDLE; synchroniser flops cleared to 0.
- Decoder FSM:
  - IDLE: wait for synced cs = 0, then go to SHIFT with bit_cnt = 0.
  - SHIFT, on a synced sclk rising edge with cs = 0:
    - Shift the synced sdin into the LSB; bit_cnt increments.
    - On the 8th edge (bit_cnt = 7), build the record {synced d_cn at that edge, byte}, push it, set bit_cnt = 0 and stay in SHIFT.
  - SHIFT, synced cs = 1:
    - If bit_cnt ≠ 0: discard the partial byte and pulse frame_abort for exactly 1 cycle.
    - Go to IDLE either way; no abort if bit_cnt = 0.
  - Falling sclk edges are ignored.
  - sclk edges while cs = 1 are ignored.
- Latency:
  - The push happens in the cycle the synced rising edge is detected.
  - rx_valid is high on the next cycle.
  - Raw link_sclk edge to rx_valid is SYNC_STAGES+2 cycles.
- FIFO (first-word-fall-through):
  - rx_data/rx_dc show the head entry whenever rx_valid = 1; when rx_valid = 0 they hold their last value.
  - A pop occurs when rx_valid & rx_ready.
  - Full, push only: the record is dropped, rx_overflow is set (sticky until reset), byte_count is unchanged.
  - Full, push and pop in the same cycle: both happen, no overflow, occupancy unchanged.
  - Empty, push: the pop is ignored that cycle, and rx_valid rises next cycle.
  - rx_ready while empty has no effect.
- byte_count: +1 per accepted push; 0xFFFF wraps to 0x0000.
- Pass-through: resn_out/vccen_out/pmoden_out equal the last synchroniser stage; latency SYNC_STAGES cycles; no decoding.

Test Plan:
1. Reset, link idle (cs = 1, sclk = 0), resn = 1 -> all outputs at reset values; resn_out = 1 after SYNC_STAGES cycles; rx_valid stays 0.
2. cs low, d_cn = 0, send 0xAF (8 sclk pulses, each clk/16), cs high -> exactly one record: rx_data = 0xAF, rx_dc = 0, rx_valid high 4 clk after the 8th raw sclk rise; byte_count = 1; no frame_abort.
3. With rx_ready = 1, one cs-low frame of 0x15, 0x00, 0x5F with d_cn = 1 -> three records in order, each with rx_dc = 1; byte_count = 3; FIFO empty afterwards.
4. cs low, 5 bits of 0xFF, cs high, then a full 0x3C frame -> one frame_abort pulse (1 cycle); only 0x3C is received; byte_count = 1.
5. rx_ready = 0, send 17 bytes 0x00..0x10 -> 16 entries 0x00..0x0F; rx_overflow = 1 after the 17th; byte_count = 16. Then set rx_ready = 1 and push 0x20 in the same cycle as a pop -> occupancy stays 16, no change to the overflow state.
6. Assert reset after 4 bits of a byte, release, send 0x81 -> reset values restored; only 0x81 is received; byte_count = 1; frame_abort never pulses.

Source files
------------

// File: rtl/oled_spi_link_rx_if.sv
// Record stream from the OLED link receiver: one {d_cn, byte} record per
// transfer, first-word-fall-through valid/ready handshake.
interface oled_spi_link_rx_if;
  logic [7:0] rx_data;   // head record byte
  logic       rx_dc;     // head record d_cn (1 = data, 0 = command)
  logic       rx_valid;  // FIFO holds at least one record
  logic       rx_ready;  // consumer takes the head record this cycle

  // Producer side (the receiver)
  modport master (
    output rx_data,
    output rx_dc,
    output rx_valid,
    input  rx_ready
  );

  // Consumer side
  modport slave (
    input  rx_data,
    input  rx_dc,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/oled_spi_link_rx.sv
// Slave-side receiver for the OLED SPI wires forwarded over the PMOD link.
// Link inputs are synchronised into clk, mode-0 SPI bytes are decoded into
// {d_cn, byte} records and queued in a small first-word-fall-through FIFO.
// The OLED power/reset controls are passed through synchronisers only.
// FIFO_DEPTH must be a power of two (>= 2); SYNC_STAGES must be >= 2.
module oled_spi_link_rx #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 link_cs,
  input  logic                 link_sdin,
  input  logic                 link_sclk,
  input  logic                 link_d_cn,
  input  logic                 link_resn,
  input  logic                 link_vccen,
  input  logic                 link_pmoden,
  oled_spi_link_rx_if.master   rx,
  output logic                 rx_overflow,
  output logic                 frame_abort,
  output logic [15:0]          byte_count,
  output logic                 resn_out,
  output logic                 vccen_out,
  output logic                 pmoden_out
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int NUM_LINK = 7;

  // Bit positions of each link wire inside the synchroniser vector
  localparam int B_CS     = 0;
  localparam int B_SDIN   = 1;
  localparam int B_SCLK   = 2;
  localparam int B_DCN    = 3;
  localparam int B_RESN   = 4;
  localparam int B_VCCEN  = 5;
  localparam int B_PMODEN = 6;

  // ---------------------------------------------------------------------
  // Synchronisers
  // ---------------------------------------------------------------------
  logic [NUM_LINK-1:0] link_raw;
  logic [NUM_LINK-1:0] link_sync;

  assign link_raw = {link_pmoden, link_vccen, link_resn, link_d_cn,
                     link_sclk, link_sdin, link_cs};

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      logic [NUM_LINK-1:0] stage_reg;
      if (gi == 0) begin : g_first
        // First flop of every chain samples the asynchronous link wires
        always_ff @(posedge clk) begin
          if (reset) stage_reg <= '0;
          else       stage_reg <= link_raw;
        end
      end else begin : g_next
        // Later flops just extend the chain
        always_ff @(posedge clk) begin
          if (reset) stage_reg <= '0;
          else       stage_reg <= g_sync[gi-1].stage_reg;
        end
      end
    end
  endgenerate

  assign link_sync = g_sync[SYNC_STAGES-1].stage_reg;

  logic cs_s, sdin_s, sclk_s, dcn_s;
  assign cs_s   = link_sync[B_CS];
  assign sdin_s = link_sync[B_SDIN];
  assign sclk_s = link_sync[B_SCLK];
  assign dcn_s  = link_sync[B_DCN];

  assign resn_out   = link_sync[B_RESN];
  assign vccen_out  = link_sync[B_VCCEN];
  assign pmoden_out = link_sync[B_PMODEN];

  // ---------------------------------------------------------------------
  // Edge detection on synced sclk and cs
  // ---------------------------------------------------------------------
  logic sclk_d_reg, cs_d_reg;
  logic sclk_rise, cs_rise;

  // One-cycle delayed copies for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_d_reg <= 1'b0;
      cs_d_reg   <= 1'b0;
    end else begin
      sclk_d_reg <= sclk_s;
      cs_d_reg   <= cs_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d_reg;
  assign cs_rise   = cs_s & ~cs_d_reg;

  // ---------------------------------------------------------------------
  // Decoder FSM
  // ---------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t     state_reg,   state_next;
  logic [7:0] shift_reg,   shift_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic       push_reg,    push_next;
  logic [8:0] rec_reg,     rec_next;
  logic       abort_reg,   abort_next;

  // Decoder state and the registered record/abort strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      push_reg    <= 1'b0;
      rec_reg     <= '0;
      abort_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      push_reg    <= push_next;
      rec_reg     <= rec_next;
      abort_reg   <= abort_next;
    end
  end

  // Next-state: shift on rising sclk while selected, drop partial bytes on cs release
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    push_next    = 1'b0;
    rec_next     = rec_reg;
    abort_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!cs_s) begin
          state_next   = ST_SHIFT;
          bit_cnt_next = '0;
          shift_next   = '0;
        end
      end
      ST_SHIFT: begin
        if (cs_s) begin
          // cs_rise is always true on the first cs-high cycle seen in SHIFT
          abort_next   = cs_rise & (bit_cnt_reg != 3'd0);
          state_next   = ST_IDLE;
          bit_cnt_next = '0;
          shift_next   = '0;
        end else if (sclk_rise) begin
          shift_next = {shift_reg[6:0], sdin_s};
          if (bit_cnt_reg == 3'd7) begin
            push_next    = 1'b1;
            rec_next     = {dcn_s, shift_next};
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign frame_abort = abort_reg;

  // ---------------------------------------------------------------------
  // Record FIFO (first-word-fall-through via a registered head)
  // ---------------------------------------------------------------------
  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_idx_reg, rd_idx_reg, rd_idx_next;
  logic [AW:0]   count_reg,  count_next;
  logic [8:0]    head_reg,   head_next;
  logic          valid_reg;
  logic          overflow_reg;
  logic [15:0]   byte_count_reg;
  logic          full, pop, do_write;

  assign full     = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign pop      = valid_reg & rx.rx_ready;
  assign do_write = push_reg & (~full | pop);

  // Pointer/occupancy bookkeeping and the next head entry
  always_comb begin
    rd_idx_next = pop ? rd_idx_reg + 1'b1 : rd_idx_reg;
    count_next  = count_reg;
    case ({do_write, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
    // A record written into the slot that becomes head must bypass the array
    if (do_write && (wr_idx_reg == rd_idx_next)) head_next = rec_reg;
    else                                         head_next = mem[rd_idx_next];
  end

  // Record storage; no reset so it maps onto plain RAM
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_idx_reg] <= rec_reg;
  end

  // FIFO control, head register and status counters
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx_reg     <= '0;
      rd_idx_reg     <= '0;
      count_reg      <= '0;
      head_reg       <= '0;
      valid_reg      <= 1'b0;
      overflow_reg   <= 1'b0;
      byte_count_reg <= '0;
    end else begin
      rd_idx_reg <= rd_idx_next;
      count_reg  <= count_next;
      valid_reg  <= (count_next != '0);
      if (count_next != '0) head_reg <= head_next;
      if (do_write) begin
        wr_idx_reg     <= wr_idx_reg + 1'b1;
        byte_count_reg <= byte_count_reg + 16'd1;
      end
      if (push_reg && full && !pop) overflow_reg <= 1'b1;
    end
  end

  assign rx.rx_data  = head_reg[7:0];
  assign rx.rx_dc    = head_reg[8];
  assign rx.rx_valid = valid_reg;
  assign rx_overflow = overflow_reg;
  assign byte_count  = byte_count_reg;

endmodule

// File: tb/tb_oled_spi_link_rx.sv
// Bench for oled_spi_link_rx: directed scenarios plus randomized frames,
// checked against an expected-record queue built from the bytes sent.
module tb_oled_spi_link_rx;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        link_cs, link_sdin, link_sclk, link_d_cn;
  logic        link_resn, link_vccen, link_pmoden;
  logic        rx_overflow, frame_abort;
  logic [15:0] byte_count;
  logic        resn_out, vccen_out, pmoden_out;

  oled_spi_link_rx_if rx_if ();

  oled_spi_link_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .link_cs     (link_cs),
    .link_sdin   (link_sdin),
    .link_sclk   (link_sclk),
    .link_d_cn   (link_d_cn),
    .link_resn   (link_resn),
    .link_vccen  (link_vccen),
    .link_pmoden (link_pmoden),
    .rx          (rx_if),
    .rx_overflow (rx_overflow),
    .frame_abort (frame_abort),
    .byte_count  (byte_count),
    .resn_out    (resn_out),
    .vccen_out   (vccen_out),
    .pmoden_out  (pmoden_out)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [8:0] exp_q[$];      // expected {d_cn, byte} records, appended by the stimulus
  int         pop_i = 0;     // next expected record index, owned by the monitor
  int         abort_cycles = 0;
  logic       rand_ready = 1'b0;
  logic [8:0] mon_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard: every accepted record must be the next expected one
  always @(negedge clk) begin
    if (reset) begin
      pop_i = exp_q.size();
    end else begin
      if (frame_abort) abort_cycles++;
      if (rx_if.rx_valid && rx_if.rx_ready) begin
        if (pop_i < exp_q.size()) begin
          mon_exp = exp_q[pop_i];
          pop_i++;
        end else begin
          mon_exp = 'x;
        end
        check("rec", 32'({rx_if.rx_dc, rx_if.rx_data}), 32'(mon_exp));
        $display("rec dc=%0d data=0x%02h", rx_if.rx_dc, rx_if.rx_data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_ready) rx_if.rx_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Sends bits 7..1, then presents bit 0 and raises sclk; returns just after that rise
  task automatic spi_open(input logic [7:0] b, input logic dcn);
    for (int i = 7; i >= 1; i--) begin
      link_sdin = b[i]; link_d_cn = dcn;
      tick(8); link_sclk = 1'b1;
      tick(8); link_sclk = 1'b0;
    end
    link_sdin = b[0]; link_d_cn = dcn;
    tick(8); link_sclk = 1'b1;
  endtask

  task automatic spi_close();
    tick(8); link_sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b, input logic dcn);
    spi_open(b, dcn);
    spi_close();
  endtask

  task automatic spi_partial(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      link_sdin = b[7-i];
      tick(8); link_sclk = 1'b1;
      tick(8); link_sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    link_cs = 1'b0; tick(4);
  endtask

  task automatic cs_high();
    tick(4); link_cs = 1'b1; tick(8);
  endtask

  task automatic do_reset();
    reset = 1'b1; link_cs = 1'b1; link_sclk = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(4);
  endtask

  function automatic logic [31:0] pending();
    return 32'(exp_q.size() - pop_i);
  endfunction

  initial begin
    int ab0, exp_ab, total, nb;
    logic [7:0] v;
    logic d;

    // 1: reset with idle link
    reset = 1'b1; link_cs = 1'b1; link_sclk = 1'b0; link_sdin = 1'b0; link_d_cn = 1'b0;
    link_resn = 1'b1; link_vccen = 1'b1; link_pmoden = 1'b1; rx_if.rx_ready = 1'b0;
    tick(3);
    check("rst_valid",    32'(rx_if.rx_valid), 32'd0);
    check("rst_data",     32'(rx_if.rx_data),  32'd0);
    check("rst_dc",       32'(rx_if.rx_dc),    32'd0);
    check("rst_overflow", 32'(rx_overflow),    32'd0);
    check("rst_abort",    32'(frame_abort),    32'd0);
    check("rst_count",    32'(byte_count),     32'd0);
    check("rst_resn",     32'(resn_out),       32'd0);
    check("rst_vccen",    32'(vccen_out),      32'd0);
    check("rst_pmoden",   32'(pmoden_out),     32'd0);
    reset = 1'b0;
    tick(1);
    check("resn_1cyc",    32'(resn_out),       32'd0);
    tick(1);
    check("resn_2cyc",    32'(resn_out),       32'd1);
    check("vccen_2cyc",   32'(vccen_out),      32'd1);
    check("pmoden_2cyc",  32'(pmoden_out),     32'd1);
    tick(20);
    check("idle_valid",   32'(rx_if.rx_valid), 32'd0);

    // 2: single command byte, latency from 8th raw sclk rise
    ab0 = abort_cycles;
    cs_low();
    exp_q.push_back({1'b0, 8'hAF});
    spi_open(8'hAF, 1'b0);
    tick(3);
    check("t2_valid_3clk", 32'(rx_if.rx_valid), 32'd0);
    tick(1);
    check("t2_valid_4clk", 32'(rx_if.rx_valid), 32'd1);
    check("t2_data",       32'(rx_if.rx_data),  32'hAF);
    check("t2_dc",         32'(rx_if.rx_dc),    32'd0);
    spi_close();
    cs_high();
    check("t2_count",      32'(byte_count),     32'd1);
    check("t2_abort",      32'(abort_cycles - ab0), 32'd0);
    rx_if.rx_ready = 1'b1;
    tick(4);
    check("t2_pending",    pending(),           32'd0);
    check("t2_empty",      32'(rx_if.rx_valid), 32'd0);

    // 3: three data bytes in one frame
    do_reset();
    rx_if.rx_ready = 1'b1;
    exp_q.push_back({1'b1, 8'h15});
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'h5F});
    cs_low();
    spi_byte(8'h15, 1'b1);
    spi_byte(8'h00, 1'b1);
    spi_byte(8'h5F, 1'b1);
    cs_high();
    tick(4);
    check("t3_count",   32'(byte_count),     32'd3);
    check("t3_pending", pending(),           32'd0);
    check("t3_empty",   32'(rx_if.rx_valid), 32'd0);

    // 4: aborted partial byte, then a full byte
    do_reset();
    rx_if.rx_ready = 1'b1;
    ab0 = abort_cycles;
    cs_low();
    spi_partial(8'hFF, 5);
    cs_high();
    check("t4_abort_pulse", 32'(abort_cycles - ab0), 32'd1);
    exp_q.push_back({1'b0, 8'h3C});
    cs_low();
    spi_byte(8'h3C, 1'b0);
    cs_high();
    tick(4);
    check("t4_count",   32'(byte_count),          32'd1);
    check("t4_pending", pending(),                32'd0);
    check("t4_abort",   32'(abort_cycles - ab0),  32'd1);

    // 5: overflow with consumer stalled, then push and pop together while full
    do_reset();
    rx_if.rx_ready = 1'b0;
    cs_low();
    for (int i = 0; i <= DEPTH; i++) begin
      if (i < DEPTH) exp_q.push_back({1'b0, 8'(i)});
      spi_byte(8'(i), 1'b0);
      if (i == DEPTH - 1) begin
        tick(2);
        check("t5_no_ovf_16", 32'(rx_overflow), 32'd0);
      end
    end
    tick(4);
    check("t5_overflow", 32'(rx_overflow),    32'd1);
    check("t5_count16",  32'(byte_count),     32'd16);
    check("t5_valid",    32'(rx_if.rx_valid), 32'd1);
    cs_high();
    exp_q.push_back({1'b0, 8'h20});
    cs_low();
    spi_open(8'h20, 1'b0);
    tick(3);
    rx_if.rx_ready = 1'b1;
    tick(1);
    rx_if.rx_ready = 1'b0;
    check("t5_count17",  32'(byte_count),  32'd17);
    check("t5_ovf_kept", 32'(rx_overflow), 32'd1);
    spi_close();
    cs_high();
    check("t5_pending16", pending(), 32'd16);
    rx_if.rx_ready = 1'b1;
    tick(40);
    check("t5_drained", pending(),           32'd0);
    check("t5_empty",   32'(rx_if.rx_valid), 32'd0);

    // 6: reset mid-byte, then a clean byte
    do_reset();
    rx_if.rx_ready = 1'b1;
    ab0 = abort_cycles;
    cs_low();
    spi_partial(8'hA5, 4);
    reset = 1'b1;
    tick(2);
    check("t6_rst_valid", 32'(rx_if.rx_valid), 32'd0);
    check("t6_rst_count", 32'(byte_count),     32'd0);
    check("t6_rst_resn",  32'(resn_out),       32'd0);
    check("t6_rst_data",  32'(rx_if.rx_data),  32'd0);
    reset = 1'b0;
    link_cs = 1'b1;
    tick(8);
    exp_q.push_back({1'b0, 8'h81});
    cs_low();
    spi_byte(8'h81, 1'b0);
    cs_high();
    tick(4);
    check("t6_count",   32'(byte_count),         32'd1);
    check("t6_pending", pending(),               32'd0);
    check("t6_abort",   32'(abort_cycles - ab0), 32'd0);

    // Randomized frames with random consumer backpressure
    do_reset();
    ab0 = abort_cycles;
    exp_ab = 0;
    total = 0;
    rand_ready = 1'b1;
    for (int f = 0; f < 8; f++) begin
      cs_low();
      nb = int'($urandom_range(1, 4));
      for (int b = 0; b < nb; b++) begin
        v = 8'($urandom_range(0, 255));
        d = 1'($urandom_range(0, 1));
        exp_q.push_back({d, v});
        spi_byte(v, d);
        total++;
      end
      if ($urandom_range(0, 2) == 0) begin
        v = 8'($urandom_range(0, 255));
        spi_partial(v, int'($urandom_range(1, 7)));
        exp_ab++;
      end
      cs_high();
    end
    rand_ready = 1'b0;
    rx_if.rx_ready = 1'b1;
    tick(40);
    check("rnd_count",    32'(byte_count),         32'(total));
    check("rnd_aborts",   32'(abort_cycles - ab0), 32'(exp_ab));
    check("rnd_pending",  pending(),               32'd0);
    check("rnd_overflow", 32'(rx_overflow),        32'd0);
    check("rnd_empty",    32'(rx_if.rx_valid),     32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
